// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory slave for the mem_bus port of the bus matrix.
// Takes one core load/store at a time, drives a single-port synchronous SRAM,
// steers byte lanes for stores and extracts/extends load data.
// Optional feature macro: MEM_BUS_MISALIGN_EN (fault misaligned half/word
// accesses with rsp_err instead of silently aligning them).
module mem_bus_ctrl #(
    parameter int WORD_AW      = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               sram_en,
    output logic [3:0]         sram_be,
    output logic [WORD_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Byte enables for a store of the given size at lane offset off.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate LSB-justified store data across every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            2'd0:    wd = {4{wdata[7:0]}};
            2'd1:    wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

    // Pull the addressed byte/half out of a SRAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(rdata >> {off, 3'b000});
        h = 16'(rdata >> {off[1], 4'b0000});
        case (size)
            2'd0:    r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    state_t               state_r;
    state_t               next_state_s;
    logic [1:0]           off_s;
    logic                 misalign_s;
    logic                 we_r;
    logic [1:0]           size_r;
    logic                 uns_r;
    logic [1:0]           off_r;
    logic [1:0]           cnt_r;
    logic                 req_ready_r;
    logic                 rsp_valid_r;
    logic [31:0]          rsp_rdata_r;
    logic                 rsp_err_r;
    logic                 sram_en_r;
    logic [3:0]           sram_be_r;
    logic [WORD_AW-1:0]   sram_addr_r;
    logic [31:0]          sram_wdata_r;
    logic                 unused_s;

    // Address bits above the SRAM window carry no meaning here.
    assign unused_s = ^req_addr[31:WORD_AW+2];

    // Lane offset of the incoming request, forced to natural alignment per size.
    always_comb begin
        off_s = 2'b00;
        case (req_size)
            2'd0:    off_s = req_addr[1:0];
            2'd1:    off_s = {req_addr[1], 1'b0};
            default: off_s = 2'b00;
        endcase
    end

`ifdef MEM_BUS_MISALIGN_EN
    // Flag half accesses on odd bytes and word accesses off a word boundary.
    always_comb begin
        misalign_s = 1'b0;
        case (req_size)
            2'd0:    misalign_s = 1'b0;
            2'd1:    misalign_s = req_addr[0];
            default: misalign_s = (req_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode for the request -> access -> wait -> response sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    if (misalign_s) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_ACCESS;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_r) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 2'd0) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Registered outputs, request capture, read-latency counter and response data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_r  <= 1'b0;
            sram_en_r    <= 1'b0;
            sram_be_r    <= 4'h0;
            sram_addr_r  <= '0;
            sram_wdata_r <= 32'h0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'h0;
            rsp_err_r    <= 1'b0;
            cnt_r        <= 2'd0;
            we_r         <= 1'b0;
            size_r       <= 2'd0;
            uns_r        <= 1'b0;
            off_r        <= 2'd0;
        end else begin
            req_ready_r <= (next_state_s == ST_IDLE);
            sram_en_r   <= (next_state_s == ST_ACCESS);
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        we_r         <= req_we;
                        size_r       <= req_size;
                        uns_r        <= req_unsigned;
                        off_r        <= off_s;
                        sram_addr_r  <= req_addr[WORD_AW+1:2];
                        sram_be_r    <= req_we ? lane_be(req_size, off_s) : 4'h0;
                        sram_wdata_r <= lane_wdata(req_size, req_wdata);
                        if (misalign_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= 32'h0;
                            rsp_err_r   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    sram_be_r <= 4'h0;
                    cnt_r     <= 2'(READ_LATENCY - 1);
                    if (we_r) begin
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= 32'h0;
                        rsp_err_r   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 2'd0) begin
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= load_extract(sram_rdata, size_r, off_r, uns_r);
                        rsp_err_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'h0;
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;
    assign sram_en    = sram_en_r;
    assign sram_be    = sram_be_r;
    assign sram_addr  = sram_addr_r;
    assign sram_wdata = sram_wdata_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: SRAM model with configurable read latency,
// a byte-level reference memory, a directed vector table and random traffic.
// Honours MEM_BUS_MISALIGN_EN the same way the design does.
module tb_mem_bus_ctrl;

    localparam int AW = 14;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [31:0]   req_addr, req_wdata;
    logic [1:0]    req_size;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          sram_en;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata, sram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.WORD_AW(AW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .sram_en(sram_en), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM model: data valid exactly RL cycles after the strobe, junk otherwise.
    logic [31:0] sram_mem [1<<AW];
    logic [31:0] rd_pipe  [RL];
    logic        mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= 32'h0;
        end else if (sram_en) begin
            for (int i = 0; i < 4; i++)
                if (sram_be[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
        if (sram_en && sram_be == 4'h0) rd_pipe[0] <= sram_mem[sram_addr];
        else                            rd_pipe[0] <= 32'hA5C3_5A3C;
        for (int j = 1; j < RL; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign sram_rdata = rd_pipe[RL-1];

    // Reference: byte-addressed little-endian memory image.
    logic [7:0] ref_mem [int];

    typedef struct {
        logic [31:0]   rd;
        logic          err;
        logic [3:0]    be;
        logic [31:0]   sw;
        logic [AW-1:0] sa;
        int            lat;
        int            ens;
        logic          chk_sw;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [3:0]  be;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Expected outcome of one request from the byte-level view of memory.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
        int n, ba, a;
        logic [31:0] v;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ba = int'(addr[AW+1:0]);
        a  = ba - (ba % n);
        e.rd = 32'h0; e.err = 1'b0; e.be = 4'h0; e.sw = 32'h0; e.sa = '0;
        e.lat = 0; e.ens = 0; e.chk_sw = 1'b0;
`ifdef MEM_BUS_MISALIGN_EN
        if (a != ba) begin
            e.err = 1'b1;
            e.lat = 1;
            return;
        end
`endif
        e.sa  = AW'(a >> 2);
        e.ens = 1;
        if (we) begin
            e.lat    = 2;
            e.chk_sw = 1'b1;
            for (int i = 0; i < 4; i++) e.sw[8*i +: 8] = wd[8*(i % n) +: 8];
            for (int i = 0; i < n; i++) begin
                e.be[(a % 4) + i] = 1'b1;
                ref_mem[a + i]    = wd[8*i +: 8];
            end
        end else begin
            e.lat = 2 + RL;
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_byte(a + i)) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
            e.rd = v;
        end
    endtask

    // Issue one request, observe the SRAM side and response, optionally stall the response.
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input exp_t e, input int stall, input string tag);
        int guard, lat, ens, busy_rdy;
        logic [3:0]    be_o;
        logic [31:0]   sw_o;
        logic [AW-1:0] sa_o;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
        chk({tag, "/idle_ready"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        lat = 0; ens = 0; busy_rdy = 0; be_o = 4'h0; sw_o = 32'h0; sa_o = '0;
        do begin
            @(negedge clk);
            lat++;
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_we    = ~we;
            if (sram_en) begin ens++; be_o = sram_be; sw_o = sram_wdata; sa_o = sram_addr; end
            if (req_ready) busy_rdy++;
        end while (rsp_valid !== 1'b1 && lat < 20);
        req_valid = 1'b0;
        chk({tag, "/latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "/sram_en_count"}, 32'(ens), 32'(e.ens));
        chk({tag, "/busy_ready"}, 32'(busy_rdy), 32'h0);
        chk({tag, "/rdata"}, rsp_rdata, e.rd);
        chk({tag, "/err"}, 32'(rsp_err), 32'(e.err));
        chk({tag, "/be"}, 32'(be_o), 32'(e.be));
        chk({tag, "/sram_addr"}, 32'(sa_o), 32'(e.sa));
        if (e.chk_sw) chk({tag, "/sram_wdata"}, sw_o, e.sw);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "/stall_valid"}, 32'(rsp_valid), 32'h1);
            chk({tag, "/stall_rdata"}, rsp_rdata, e.rd);
            chk({tag, "/stall_ready"}, 32'(req_ready), 32'h0);
            chk({tag, "/stall_sram_en"}, 32'(sram_en), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "/rsp_done"}, 32'(rsp_valid), 32'h0);
        chk({tag, "/ready_after"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        exp_t e;
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] addr, wd;

        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'hF});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_0080, 32'h0, 1'b0, 4'b1000});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_0080, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h8001_1234, 32'h0, 1'b0, 4'hF});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'hFFFF_8001, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_1234, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1'b0, 4'b1100});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFF_0200, 32'h0, 32'hABCD_0000, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h0000_0300, 32'h1122_3344, 32'h0, 1'b0, 4'hF});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h0000_0300, 32'h0, 32'h1122_3344, 1'b0, 4'h0});
`ifdef MEM_BUS_MISALIGN_EN
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 4'h0});
`else
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'h8001_1234, 1'b0, 4'h0});
`endif

        rst = 1'b0; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/req_ready", 32'(req_ready), 32'h0);
        chk("reset/rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset/rsp_rdata", rsp_rdata, 32'h0);
        chk("reset/rsp_err", 32'(rsp_err), 32'h0);
        chk("reset/sram_en", 32'(sram_en), 32'h0);
        chk("reset/sram_be", 32'(sram_be), 32'h0);
        chk("reset/sram_addr", 32'(sram_addr), 32'h0);
        chk("reset/sram_wdata", sram_wdata, 32'h0);
        mem_clr = 1'b0;
        rst = 1'b1;
        #1;
        chk("release/ready_low", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("release/ready_high", 32'(req_ready), 32'h1);

        // Directed table: rdata/err/be from fixed values, timing from the model.
        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, e);
            e.rd = vecs[i].rd; e.err = vecs[i].err; e.be = vecs[i].be;
            run_txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                    e, 0, $sformatf("vec%0d", i));
        end

        // Response back-pressure on a load.
        model(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, e);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, e, 5, "backpressure");

        // Reset while waiting on SRAM read data.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset/rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midreset/sram_en", 32'(sram_en), 32'h0);
        chk("midreset/req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset/ready_after", 32'(req_ready), 32'h1);
        chk("midreset/no_stale_rsp", 32'(rsp_valid), 32'h0);
        model(1'b0, 2'd0, 1'b1, 32'h0000_0302, 32'h0, e);
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0302, 32'h0, e, 0, "post_reset");

        // Random traffic in a small window, junk in the ignored upper address bits.
        for (int t = 0; t < 80; t++) begin
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = ($urandom & 32'hFFFF_0000) | (32'h0000_0200 + 32'($urandom_range(0, 63)));
            wd   = $urandom;
            model(we, sz, uns, addr, wd, e);
            run_txn(we, sz, uns, addr, wd, e, $urandom_range(0, 2), $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
